// File: rtl/reference_filter_mc_pkg.sv
// Shared definitions for the multi-channel reference qualifier:
// per-channel FSM encoding and a constant-width helper.
package reference_filter_mc_pkg;

  localparam logic [1:0] ST_GUARD = 2'd0;
  localparam logic [1:0] ST_QUAL  = 2'd1;
  localparam logic [1:0] ST_OK    = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  function automatic int CLOG2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/ref_filter_ch.sv
// One reference channel: 2-FF synchroniser, guard timer, saturating
// leaky filter counter, QUAL dwell counter and the GUARD/QUAL/OK/FAULT FSM.
module ref_filter_ch
  import reference_filter_mc_pkg::*;
#(
  parameter int CTR_WIDTH    = 8,
  parameter int GUARD_TICKS  = 1000,
  parameter int LOW_HOLD_TKS = 5000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ref_raw_i,
  input  logic                 guard_start_i,
  input  logic                 fault_clr_i,
  input  logic [CTR_WIDTH-1:0] rise_thresh_i,
  input  logic [CTR_WIDTH-1:0] fall_thresh_i,
  input  logic                 cfg_err_i,
  output logic                 ref_ok_o,
  output logic                 rise_pulse_o,
  output logic                 fall_pulse_o,
  output logic                 guard_active_o,
  output logic                 fault_o
);

  localparam int GW = (CLOG2(GUARD_TICKS + 1) < 1) ? 1 : CLOG2(GUARD_TICKS + 1);
  localparam int LW = (CLOG2(LOW_HOLD_TKS + 1) < 1) ? 1 : CLOG2(LOW_HOLD_TKS + 1);
  localparam logic [GW-1:0]        GLOAD   = GW'(GUARD_TICKS);
  localparam logic [LW-1:0]        LOW_LIM = LW'(LOW_HOLD_TKS);
  localparam logic [CTR_WIDTH-1:0] ACC_MAX = '1;

  logic [1:0]           sync_q;
  logic                 ref_sync;
  logic [GW-1:0]        gtmr;
  logic [CTR_WIDTH-1:0] acc;
  logic [LW-1:0]        low_cnt;
  logic [1:0]           state, next_state;
  logic                 tmr_load, guard_hit;
  logic                 rise_nxt, fall_nxt;

  assign ref_sync = sync_q[1];

  // A load in the current cycle counts as guard already, so the FSM reacts
  // on the same edge that samples guard_start_i / fault_clr_i.
  assign tmr_load  = guard_start_i | ((state == ST_FAULT) & fault_clr_i);
  assign guard_hit = tmr_load | (gtmr != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      gtmr    <= '0;
      acc     <= '0;
      low_cnt <= '0;
    end else begin
      sync_q <= {sync_q[0], ref_raw_i};

      if (tmr_load)          gtmr <= GLOAD;
      else if (gtmr != '0)   gtmr <= gtmr - 1'b1;

      if (guard_hit)                        acc <= '0;
      else if (ref_sync && acc != ACC_MAX)  acc <= acc + 1'b1;
      else if (!ref_sync && acc != '0)      acc <= acc - 1'b1;

      if (state == ST_QUAL) begin
        if (low_cnt != LOW_LIM) low_cnt <= low_cnt + 1'b1;
      end else begin
        low_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_GUARD;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_GUARD: if (!guard_hit) next_state = ST_QUAL;
      ST_QUAL: begin
        if (guard_hit)                                         next_state = ST_GUARD;
        else if ((LOW_HOLD_TKS > 0) && (low_cnt == LOW_LIM))   next_state = ST_FAULT;
        else if (!cfg_err_i && (acc >= rise_thresh_i))         next_state = ST_OK;
      end
      ST_OK: begin
        if (guard_hit)                   next_state = ST_GUARD;
        else if (acc <= fall_thresh_i)   next_state = ST_QUAL;
      end
      ST_FAULT: if (fault_clr_i) next_state = ST_GUARD;
      default:  next_state = ST_GUARD;
    endcase
  end

  always_comb begin
    rise_nxt = (state != ST_OK) && (next_state == ST_OK);
    fall_nxt = (state == ST_OK) && (next_state != ST_OK);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rise_pulse_o <= 1'b0;
      fall_pulse_o <= 1'b0;
    end else begin
      rise_pulse_o <= rise_nxt;
      fall_pulse_o <= fall_nxt;
    end
  end

  assign ref_ok_o       = (state == ST_OK);
  assign fault_o        = (state == ST_FAULT);
  assign guard_active_o = (gtmr != '0);

endmodule

// File: rtl/reference_filter_mc.sv
// N_CH independent reference qualifiers plus shared threshold sanity
// check and aggregate status.
module reference_filter_mc
  import reference_filter_mc_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int CTR_WIDTH    = 8,
  parameter int GUARD_TICKS  = 1000,
  parameter int LOW_HOLD_TKS = 5000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N_CH-1:0]      ref_raw_i,
  input  logic [N_CH-1:0]      guard_start_i,
  input  logic [N_CH-1:0]      fault_clr_i,
  input  logic [CTR_WIDTH-1:0] rise_thresh_i,
  input  logic [CTR_WIDTH-1:0] fall_thresh_i,
  output logic [N_CH-1:0]      ref_ok_o,
  output logic [N_CH-1:0]      rise_pulse_o,
  output logic [N_CH-1:0]      fall_pulse_o,
  output logic [N_CH-1:0]      guard_active_o,
  output logic [N_CH-1:0]      fault_o,
  output logic                 all_ok_o,
  output logic                 any_fault_o,
  output logic                 cfg_err_o
);

  // Inverted or collapsed hysteresis blocks new qualification only.
  assign cfg_err_o = (rise_thresh_i <= fall_thresh_i);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    ref_filter_ch #(
      .CTR_WIDTH    (CTR_WIDTH),
      .GUARD_TICKS  (GUARD_TICKS),
      .LOW_HOLD_TKS (LOW_HOLD_TKS)
    ) u_ch (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .ref_raw_i      (ref_raw_i[g]),
      .guard_start_i  (guard_start_i[g]),
      .fault_clr_i    (fault_clr_i[g]),
      .rise_thresh_i  (rise_thresh_i),
      .fall_thresh_i  (fall_thresh_i),
      .cfg_err_i      (cfg_err_o),
      .ref_ok_o       (ref_ok_o[g]),
      .rise_pulse_o   (rise_pulse_o[g]),
      .fall_pulse_o   (fall_pulse_o[g]),
      .guard_active_o (guard_active_o[g]),
      .fault_o        (fault_o[g])
    );
  end

  assign all_ok_o    = &ref_ok_o;
  assign any_fault_o = |fault_o;

endmodule

// File: tb/tb_reference_filter_mc.sv
// Directed bench for reference_filter_mc: expectations are scheduled into a
// cycle-ordered scoreboard at stimulus time and checked on the falling edge.
module tb_reference_filter_mc;
  localparam int N  = 4;
  localparam int CW = 8;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [N-1:0]  ref_raw_i, guard_start_i, fault_clr_i;
  logic [CW-1:0] rise_thresh_i, fall_thresh_i;
  logic [N-1:0]  ref_ok_o, rise_pulse_o, fall_pulse_o, guard_active_o, fault_o;
  logic          all_ok_o, any_fault_o, cfg_err_o;

  reference_filter_mc #(.N_CH(N), .CTR_WIDTH(CW), .GUARD_TICKS(1000), .LOW_HOLD_TKS(5000)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .ref_raw_i(ref_raw_i), .guard_start_i(guard_start_i),
    .fault_clr_i(fault_clr_i), .rise_thresh_i(rise_thresh_i), .fall_thresh_i(fall_thresh_i),
    .ref_ok_o(ref_ok_o), .rise_pulse_o(rise_pulse_o), .fall_pulse_o(fall_pulse_o),
    .guard_active_o(guard_active_o), .fault_o(fault_o), .all_ok_o(all_ok_o),
    .any_fault_o(any_fault_o), .cfg_err_o(cfg_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef enum {S_OK, S_RP, S_FP, S_GA, S_FLT, S_ALL, S_ANY} sel_e;
  typedef struct {int cyc; string tag; sel_e sel; int ch; logic val;} exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0, ncmp = 0, nerr = 0;
  int   tf;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(string tag, logic obs, logic exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic probe(sel_e s, int ch);
    case (s)
      S_OK:    return ref_ok_o[ch];
      S_RP:    return rise_pulse_o[ch];
      S_FP:    return fall_pulse_o[ch];
      S_GA:    return guard_active_o[ch];
      S_FLT:   return fault_o[ch];
      S_ALL:   return all_ok_o;
      default: return any_fault_o;
    endcase
  endfunction

  task automatic expect_abs(int at, string tag, sel_e s, int ch, logic v);
    exp_t e;
    int   i;
    e = '{at, tag, s, ch, v};
    i = 0;
    while (i < sb.size() && sb[i].cyc <= at) i++;
    sb.insert(i, e);
  endtask

  task automatic expect_at(int dc, string tag, sel_e s, int ch, logic v);
    expect_abs(cyc + dc, tag, s, ch, v);
  endtask

  // Monitor: pops every expectation whose edge has been reached.
  always @(negedge clk_i) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.cyc < cyc) begin
        ncmp++; nerr++;
        $error("FAIL %s: observed nothing at edge %0d expected a check", mon_e.tag, mon_e.cyc);
      end else begin
        chk($sformatf("%s[%0d]@%0d", mon_e.tag, mon_e.ch, mon_e.cyc), probe(mon_e.sel, mon_e.ch), mon_e.val);
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(negedge clk_i);
    #1;
  endtask

  task automatic drain(int lim);
    int b;
    b = 0;
    while (sb.size() > 0 && b < lim) begin
      step(1);
      b++;
    end
    if (sb.size() > 0) begin
      ncmp++; nerr++;
      $error("FAIL drain: observed %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    rst_i = 1'b1; ref_raw_i = 4'b1110; guard_start_i = '0; fault_clr_i = '0;
    rise_thresh_i = 8'd200; fall_thresh_i = 8'd20;
    #23;
    chk("rst_ok",    |ref_ok_o, 1'b0);
    chk("rst_pulse", |{rise_pulse_o, fall_pulse_o}, 1'b0);
    chk("rst_guard", |guard_active_o, 1'b0);
    chk("rst_fault", |{fault_o, any_fault_o}, 1'b0);
    chk("rst_allok", all_ok_o, 1'b0);
    chk("rst_cfg",   cfg_err_o, 1'b0);
    step(1);
    rst_i = 1'b0;
    expect_at(1,   "boot_ga",  S_GA, 1, 1'b0);
    expect_at(202, "boot_ok",  S_OK, 1, 1'b0);
    expect_at(203, "boot_ok",  S_OK, 1, 1'b1);
    expect_at(203, "boot_ok",  S_OK, 3, 1'b1);
    expect_at(203, "boot_rp",  S_RP, 1, 1'b1);
    expect_at(204, "boot_rp",  S_RP, 1, 1'b0);
    expect_at(203, "boot_ok0", S_OK, 0, 1'b0);
    expect_at(203, "boot_all", S_ALL, 0, 1'b0);
    drain(300);
    step(100);

    // Rise latency on ch0
    ref_raw_i[0] = 1'b1;
    expect_at(202, "t1_ok",  S_OK, 0, 1'b0);
    expect_at(203, "t1_ok",  S_OK, 0, 1'b1);
    expect_at(202, "t1_rp",  S_RP, 0, 1'b0);
    expect_at(203, "t1_rp",  S_RP, 0, 1'b1);
    expect_at(204, "t1_rp",  S_RP, 0, 1'b0);
    expect_at(202, "t1_all", S_ALL, 0, 1'b0);
    expect_at(203, "t1_all", S_ALL, 0, 1'b1);
    expect_at(203, "t1_rp1", S_RP, 1, 1'b0);
    expect_at(203, "t1_ok2", S_OK, 2, 1'b1);
    drain(300);
    step(100);

    // Hysteresis: 100-cycle glitch holds OK, sustained low drops it
    ref_raw_i[0] = 1'b0;
    expect_at(50,  "t2_glitch", S_OK, 0, 1'b1);
    expect_at(102, "t2_glitch", S_OK, 0, 1'b1);
    expect_at(102, "t2_gfp",    S_FP, 0, 1'b0);
    expect_at(150, "t2_glitch", S_OK, 0, 1'b1);
    expect_at(200, "t2_glitch", S_OK, 0, 1'b1);
    step(100);
    ref_raw_i[0] = 1'b1;
    step(200);
    drain(10);
    ref_raw_i[0] = 1'b0;
    tf = cyc;
    expect_at(237, "t2_fp",  S_FP, 0, 1'b0);
    expect_at(238, "t2_fp",  S_FP, 0, 1'b1);
    expect_at(239, "t2_fp",  S_FP, 0, 1'b0);
    expect_at(237, "t2_ok",  S_OK, 0, 1'b1);
    expect_at(238, "t2_ok",  S_OK, 0, 1'b0);
    expect_at(238, "t2_all", S_ALL, 0, 1'b0);
    drain(300);

    // Guard mid-OK on ch1
    guard_start_i[1] = 1'b1;
    expect_at(1,    "t3_ok", S_OK, 1, 1'b0);
    expect_at(1,    "t3_fp", S_FP, 1, 1'b1);
    expect_at(2,    "t3_fp", S_FP, 1, 1'b0);
    expect_at(1,    "t3_ga", S_GA, 1, 1'b1);
    expect_at(1000, "t3_ga", S_GA, 1, 1'b1);
    expect_at(1001, "t3_ga", S_GA, 1, 1'b0);
    expect_at(1199, "t3_ok", S_OK, 1, 1'b0);
    expect_at(1204, "t3_ok", S_OK, 1, 1'b1);
    step(1);
    guard_start_i = '0;
    drain(1300);

    // Fault on ch0: QUAL entered at tf+238, held low for LOW_HOLD_TKS cycles
    expect_abs(tf + 238 + 4999, "t4_flt", S_FLT, 0, 1'b0);
    expect_abs(tf + 238 + 4999, "t4_any", S_ANY, 0, 1'b0);
    expect_abs(tf + 238 + 5002, "t4_flt", S_FLT, 0, 1'b1);
    expect_abs(tf + 238 + 5002, "t4_any", S_ANY, 0, 1'b1);
    drain(5000);
    ref_raw_i[0] = 1'b1;
    expect_at(400, "t4_sticky", S_FLT, 0, 1'b1);
    expect_at(400, "t4_nook",   S_OK,  0, 1'b0);
    drain(500);
    fault_clr_i[0] = 1'b1;
    guard_start_i[0] = 1'b1;
    expect_at(1,    "t4_clr",  S_FLT, 0, 1'b0);
    expect_at(1,    "t4_any",  S_ANY, 0, 1'b0);
    expect_at(1,    "t4_ga",   S_GA,  0, 1'b1);
    expect_at(1000, "t4_ga",   S_GA,  0, 1'b1);
    expect_at(1001, "t4_ga",   S_GA,  0, 1'b0);
    expect_at(1199, "t4_ok",   S_OK,  0, 1'b0);
    expect_at(1204, "t4_ok",   S_OK,  0, 1'b1);
    step(1);
    fault_clr_i = '0;
    guard_start_i = '0;
    drain(1300);

    // Config error on ch2 (all channels OK at acc=255 here)
    rise_thresh_i = 8'd19; #1 chk("t5_cfg_lt", cfg_err_o, 1'b1);
    rise_thresh_i = 8'd21; #1 chk("t5_cfg_gt", cfg_err_o, 1'b0);
    rise_thresh_i = 8'd20; #1 chk("t5_cfg_eq", cfg_err_o, 1'b1);
    guard_start_i[2] = 1'b1;
    expect_at(1, "t5_ok", S_OK, 2, 1'b0);
    expect_at(1, "t5_fp", S_FP, 2, 1'b1);
    step(1);
    guard_start_i = '0;
    step(1400);
    expect_at(1, "t5_blocked", S_OK, 2, 1'b0);
    drain(10);
    rise_thresh_i = 8'd200;
    #1 chk("t5_cfg_ok", cfg_err_o, 1'b0);
    expect_at(1, "t5_ok", S_OK, 2, 1'b1);
    expect_at(1, "t5_rp", S_RP, 2, 1'b1);
    expect_at(2, "t5_rp", S_RP, 2, 1'b0);
    drain(10);

    // Async reset with ch3 mid-guard and others OK
    guard_start_i[3] = 1'b1;
    step(1);
    guard_start_i = '0;
    step(500);
    #2 rst_i = 1'b1;
    #1;
    chk("t6_ok",    |ref_ok_o, 1'b0);
    chk("t6_ga",    |guard_active_o, 1'b0);
    chk("t6_pulse", |{rise_pulse_o, fall_pulse_o}, 1'b0);
    chk("t6_flt",   |{fault_o, any_fault_o}, 1'b0);
    chk("t6_all",   all_ok_o, 1'b0);
    step(2);
    rst_i = 1'b0;
    expect_at(1,   "t6_fp",  S_FP, 0, 1'b0);
    expect_at(1,   "t6_ga",  S_GA, 3, 1'b0);
    expect_at(202, "t6_all", S_ALL, 0, 1'b0);
    expect_at(203, "t6_all", S_ALL, 0, 1'b1);
    expect_at(203, "t6_rp",  S_RP, 3, 1'b1);
    drain(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
